bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 58 +++++
 tb/tb_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: CPU/DMA bus arbiter with turnaround cycles, DMA burst limit and minimum CPU hold time
module bus_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int MIN_CPU = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rwb,
  input  logic [15:0] cpu_addr,
  input  logic        dma_req,
  input  logic        dma_rwb,
  input  logic [15:0] dma_addr,
  output logic        dma_gnt,
  output logic        RDY,
  output logic        BE,
  output logic        RWB,
  output logic [15:0] A
);
  typedef enum logic [1:0] {CPU, TURN_D, DMA, TURN_C} state_t;
  localparam logic [7:0] HOLD_RST = 8'(MIN_CPU);
  // the cycle that hands the bus over is itself a CPU cycle, hence MIN_CPU-1
  localparam logic [7:0] HOLD_MIN = 8'(MIN_CPU - 1);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);
  state_t state;
  logic [7:0] hold_cnt, burst_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CPU;
      hold_cnt <= HOLD_RST;
      burst_cnt <= 8'd0;
    end else begin
      case (state)
        CPU: begin
          if (dma_req && cpu_rwb && hold_cnt >= HOLD_MIN) state <= TURN_D;
          if (hold_cnt != 8'hff) hold_cnt <= hold_cnt + 8'd1;
        end
        TURN_D: begin
          state <= DMA;
          burst_cnt <= 8'd0;
        end
        DMA: begin
          if (!dma_req || burst_cnt == BURST_LAST) state <= TURN_C;
          if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 8'd1;
        end
        default: begin
          state <= CPU;
          hold_cnt <= 8'd0;
        end
      endcase
    end
  end
  assign BE = state == CPU;
  assign RDY = BE;
  assign dma_gnt = state == DMA;
  assign A = BE ? cpu_addr : dma_gnt ? dma_addr : 16'h0000;
  assign RWB = BE ? cpu_rwb : dma_gnt ? dma_rwb : 1'b1;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized run against a behavioural model
module tb_bus_arbiter;
  localparam int MAX_BURST = 8;
  localparam int MIN_CPU = 2;
  localparam int P_CPU = 0, P_TD = 1, P_DMA = 2, P_TC = 3;
  logic clk = 1'b0, reset = 1'b0, cpu_rwb = 1'b1, dma_req = 1'b0, dma_rwb = 1'b1;
  logic [15:0] cpu_addr = 16'h0, dma_addr = 16'h0;
  logic dma_gnt, RDY, BE, RWB;
  logic [15:0] A;
  int checks = 0, failures = 0;
  bus_arbiter #(.MAX_BURST(MAX_BURST), .MIN_CPU(MIN_CPU)) dut (
    .clk(clk), .reset(reset), .cpu_rwb(cpu_rwb), .cpu_addr(cpu_addr),
    .dma_req(dma_req), .dma_rwb(dma_rwb), .dma_addr(dma_addr),
    .dma_gnt(dma_gnt), .RDY(RDY), .BE(BE), .RWB(RWB), .A(A)
  );
  always #5 clk = ~clk;
  // 0: CPU owns bus, 1: turnaround, 2: DMA granted
  function automatic int code();
    return BE ? 0 : dma_gnt ? 2 : 1;
  endfunction
  task automatic do_reset();
    dma_req = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    cpu_addr = 16'hA5C3;
    cpu_rwb = 1'b0;
    do_reset();
    checks++;
    if ({BE, RDY, dma_gnt, RWB, A} !== {3'b110, 1'b0, 16'hA5C3}) begin
      failures++;
      $display("FAIL reset_outputs got=%b_%h exp=1100_a5c3", {BE, RDY, dma_gnt, RWB}, A);
    end
    cpu_rwb = 1'b1;
    #1;
    checks++;
    if (RWB !== 1'b1) begin
      failures++;
      $display("FAIL reset_rwb_follow got=%b exp=1", RWB);
    end
  endtask
  task automatic test_burst();
    int e;
    do_reset();
    dma_req = 1'b1;
    cpu_rwb = 1'b1;
    for (int i = 0; i < 14; i++) begin
      e = (i == 0) ? 0 : (i == 1) ? 1 : (i < 10) ? 2 : (i == 10) ? 1 : (i < 13) ? 0 : 1;
      checks++;
      if (code() !== e) begin
        failures++;
        $display("FAIL burst_seq[%0d] got=%0d exp=%0d", i, code(), e);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_write_hold();
    do_reset();
    dma_req = 1'b1;
    cpu_rwb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) cpu_rwb = 1'b1;
      checks++;
      if (code() !== 0) begin
        failures++;
        $display("FAIL write_hold[%0d] got=%0d exp=0", i, code());
      end
      @(negedge clk);
    end
    checks++;
    if (code() !== 1) begin
      failures++;
      $display("FAIL write_hold_turn got=%0d exp=1", code());
    end
  endtask
  task automatic test_early_drop();
    int exp_seq [6] = '{0, 1, 2, 2, 1, 0};
    int n = 0;
    do_reset();
    dma_req = 1'b1;
    cpu_rwb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (code() !== exp_seq[i]) begin
        failures++;
        $display("FAIL early_drop_seq[%0d] got=%0d exp=%0d", i, code(), exp_seq[i]);
      end
      if (dma_gnt) n++;
      if (n == 2) dma_req = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL early_drop_count got=%0d exp=2", n);
    end
  endtask
  task automatic test_addr_mux();
    do_reset();
    cpu_addr = 16'hBEEF;
    dma_addr = 16'h1234;
    dma_rwb = 1'b0;
    cpu_rwb = 1'b1;
    dma_req = 1'b1;
    #1;
    checks++;
    if ({A, RWB} !== {16'hBEEF, 1'b1}) begin
      failures++;
      $display("FAIL mux_cpu got=%h/%b exp=beef/1", A, RWB);
    end
    @(negedge clk);
    cpu_rwb = 1'b0;
    #1;
    checks++;
    if ({A, RWB, BE, RDY, dma_gnt} !== {16'h0000, 4'b1000}) begin
      failures++;
      $display("FAIL mux_turn_d got=%h/%b%b%b%b exp=0000/1000", A, RWB, BE, RDY, dma_gnt);
    end
    @(negedge clk);
    checks++;
    if ({A, RWB, BE, RDY, dma_gnt} !== {16'h1234, 4'b0001}) begin
      failures++;
      $display("FAIL mux_dma got=%h/%b%b%b%b exp=1234/0001", A, RWB, BE, RDY, dma_gnt);
    end
    dma_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({A, RWB, BE, dma_gnt} !== {16'h0000, 3'b100}) begin
      failures++;
      $display("FAIL mux_turn_c got=%h/%b%b%b exp=0000/100", A, RWB, BE, dma_gnt);
    end
    @(negedge clk);
    checks++;
    if ({A, RWB, BE} !== {16'hBEEF, 2'b01}) begin
      failures++;
      $display("FAIL mux_cpu_back got=%h/%b%b exp=beef/01", A, RWB, BE);
    end
    dma_rwb = 1'b1;
    cpu_rwb = 1'b1;
  endtask
  task automatic test_reset_mid_dma();
    do_reset();
    dma_req = 1'b1;
    cpu_rwb = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (dma_gnt !== 1'b1) begin
      failures++;
      $display("FAIL mid_dma_pre got=%b exp=1", dma_gnt);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({BE, RDY, dma_gnt} !== 3'b110) begin
      failures++;
      $display("FAIL mid_dma_reset got=%b exp=110", {BE, RDY, dma_gnt});
    end
    @(negedge clk);
    checks++;
    if (code() !== 1) begin
      failures++;
      $display("FAIL mid_dma_eligible got=%0d exp=1", code());
    end
  endtask
  task automatic test_turn_d_drop();
    int exp_seq [5] = '{0, 1, 2, 1, 0};
    do_reset();
    dma_req = 1'b1;
    cpu_rwb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (code() !== exp_seq[i]) begin
        failures++;
        $display("FAIL turn_d_drop[%0d] got=%0d exp=%0d", i, code(), exp_seq[i]);
      end
      if (i == 1) dma_req = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic test_random();
    int ph = P_CPU, cyc = MIN_CPU, grants = 0, run = 0;
    logic ebe, egnt, erwb;
    logic [15:0] ea;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      reset = $urandom_range(0, 199) == 0;
      dma_req = $urandom_range(0, 3) != 0;
      cpu_rwb = $urandom_range(0, 9) < 7;
      dma_rwb = 1'($urandom);
      cpu_addr = 16'($urandom);
      dma_addr = 16'($urandom);
      #1;
      ebe = ph == P_CPU;
      egnt = ph == P_DMA;
      ea = ebe ? cpu_addr : egnt ? dma_addr : 16'h0000;
      erwb = ebe ? cpu_rwb : egnt ? dma_rwb : 1'b1;
      checks++;
      if ({BE, RDY, dma_gnt, RWB, A} !== {ebe, ebe, egnt, erwb, ea}) begin
        failures++;
        $display("FAIL rand_outputs[%0d] got=%b_%h exp=%b_%h", i, {BE, RDY, dma_gnt, RWB}, A, {ebe, ebe, egnt, erwb}, ea);
      end
      checks++;
      if ((BE && dma_gnt) || RDY !== BE) begin
        failures++;
        $display("FAIL rand_exclusive[%0d] got BE=%b RDY=%b gnt=%b exp BE&gnt=0 RDY=BE", i, BE, RDY, dma_gnt);
      end
      run = dma_gnt ? run + 1 : 0;
      checks++;
      if (run > MAX_BURST) begin
        failures++;
        $display("FAIL rand_burst_len[%0d] got=%0d exp<=%0d", i, run, MAX_BURST);
      end
      if (reset) begin
        ph = P_CPU;
        cyc = MIN_CPU;
      end else if (ph == P_CPU) begin
        if (dma_req && cpu_rwb && cyc + 1 >= MIN_CPU) ph = P_TD;
        else cyc++;
      end else if (ph == P_TD) begin
        ph = P_DMA;
        grants = 0;
      end else if (ph == P_DMA) begin
        grants++;
        if (!dma_req || grants >= MAX_BURST) ph = P_TC;
      end else begin
        ph = P_CPU;
        cyc = 0;
      end
      @(negedge clk);
    end
    reset = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_burst();
    test_write_hold();
    test_early_drop();
    test_addr_mux();
    test_reset_mid_dma();
    test_turn_d_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
